// File: rtl/seq_mult_ctrl.sv
// Sequencing controller and shift-add datapath for an unsigned N x N sequential multiplier.
// A rising edge on start launches one N-iteration job; the 2N-bit product is registered with a one-cycle valid pulse.
module seq_mult_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] Y,
    output logic           valid,
    output logic           busy,
    output logic [1:0]     state
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt;
    logic            start_q;
    logic            launch;
    logic [N-1:0]    m_r;
    logic [N-1:0]    q_r;
    logic [N:0]      p_r;
    logic [N:0]      sum;
    logic [CW-1:0]   cnt;
    logic            zero_flag;

    // start_q resets high so a start level held through reset cannot look like a fresh edge.
    assign launch = start & ~start_q & (state_r == IDLE);
    assign sum    = p_r + (q_r[0] ? {1'b0, m_r} : '0);
    assign state  = state_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            // NOTE: sequential state is always updated with <= so every register sees pre-edge values.
            state_r <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaulting the next state first keeps this block free of inferred latches.
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (launch) begin
                    state_nxt = ((A == '0) || (B == '0)) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(N - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q   <= 1'b1;
            m_r       <= '0;
            q_r       <= '0;
            p_r       <= '0;
            cnt       <= '0;
            zero_flag <= 1'b0;
            Y         <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            start_q <= start;
            valid   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (launch) begin
                        m_r       <= A;
                        q_r       <= B;
                        p_r       <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        zero_flag <= (A == '0) || (B == '0);
                    end
                end
                CALC: begin
                    // Shift {P,Q} right by one; the low bit of the sum enters the multiplier register.
                    p_r <= sum >> 1;
                    q_r <= {sum[0], q_r[N-1:1]};
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    Y         <= zero_flag ? '0 : {p_r[N-1:0], q_r};
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                    zero_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: a job-level model predicts products and timing,
// a monitor compares valid, Y, busy and state every cycle.
module tb_seq_mult_ctrl;

    localparam int N = 8;

    logic           clk;
    logic           reset;
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [2*N-1:0] Y;
    logic           valid;
    logic           busy;
    logic [1:0]     state;

    typedef struct {
        logic [2*N-1:0] y;
        int             due;
    } exp_t;

    exp_t           sb[$];
    int             cyc;
    int             remaining;
    logic           prev_start;
    logic [2*N-1:0] last_y;
    int             checks;
    int             errors;
    int             launches;

    seq_mult_ctrl #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Y     (Y),
        .valid (valid),
        .busy  (busy),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Job-level model: a start rising edge while no job is outstanding launches A*B.
    // Nonzero jobs finish N+1 cycles later, zero-operand jobs one cycle later.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_start = 1'b1;
            remaining  = 0;
            sb.delete();
            cyc++;
        end else begin
            cyc++;
            if (start && !prev_start && remaining == 0) begin
                exp_t e;
                logic [2*N-1:0] prod;
                prod = (2*N)'(A) * (2*N)'(B);
                remaining = (A == 0 || B == 0) ? 1 : N + 1;
                e.y   = prod;
                e.due = cyc + remaining;
                sb.push_back(e);
                launches++;
            end else if (remaining > 0) begin
                remaining--;
            end
            prev_start = start;
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            last_y = '0;
        end
        if (sb.size() > 0 && sb[0].due < cyc) begin
            errors++;
            checks++;
            $display("FAIL overdue: got no valid expected Y=0x%0h due cycle %0d at cycle %0d",
                     sb[0].y, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check("valid_pulse", 64'(valid), 64'(1));
            check("product", 64'(Y), 64'(sb[0].y));
            last_y = sb[0].y;
            void'(sb.pop_front());
        end else begin
            check("no_valid", 64'(valid), 64'(0));
            check("y_hold", 64'(Y), 64'(last_y));
        end
        check("busy", 64'(busy), 64'(remaining > 0));
        check("state", 64'(state), (remaining == 0) ? 64'(0) : (remaining == 1) ? 64'(2) : 64'(1));
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_job(input logic [N-1:0] a, input logic [N-1:0] b, input int hold, input int gap);
        A     = a;
        B     = b;
        start = 1'b1;
        cycles(hold);
        start = 1'b0;
        cycles(gap);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        launches = 0;
        cyc      = 0;
        last_y   = '0;
        reset    = 1'b0;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        cycles(3);
        check("reset_y", 64'(Y), 64'(0));
        check("reset_valid", 64'(valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_state", 64'(state), 64'(0));
        #1 reset = 1'b1;
        cycles(2);

        // 13*11 with start held high: one job, no relaunch.
        pulse_job(8'd13, 8'd11, 20, 2);
        check("launch_count_13x11", 64'(launches), 64'(1));

        // Maximum operands exercise the accumulator carry bit.
        pulse_job(8'd255, 8'd255, 1, 12);
        // Zero operand takes the short path.
        pulse_job(8'd0, 8'd200, 1, 4);

        // 7*9 with operand change and a fresh start edge during CALC.
        A = 8'd7; B = 8'd9; start = 1'b1;
        cycles(2);
        start = 1'b0;
        cycles(1);
        A = 8'd3; B = 8'd3; start = 1'b1;
        cycles(12);
        start = 1'b0;
        cycles(3);
        check("launch_count_7x9", 64'(launches), 64'(4));

        // Reset in mid-CALC aborts 6*5.
        A = 8'd6; B = 8'd5; start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(3);
        #1 reset = 1'b0;
        #1;
        check("abort_y", 64'(Y), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_state", 64'(state), 64'(0));
        cycles(2);
        #1 reset = 1'b1;
        cycles(14);

        // start held high through reset release must not launch.
        start = 1'b1;
        #1 reset = 1'b0;
        cycles(2);
        A = 8'd21; B = 8'd12;
        #1 reset = 1'b1;
        cycles(12);
        check("no_launch_held", 64'(busy), 64'(0));
        start = 1'b0;
        cycles(1);
        pulse_job(8'd21, 8'd12, 2, 12);

        // Randomized jobs with corner-biased operands and stray start edges.
        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            case ($urandom_range(0, 5))
                0:       a = '0;
                1:       a = '1;
                default: a = N'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = '1;
                default: b = N'($urandom);
            endcase
            A = a;
            B = b;
            start = 1'b1;
            cycles($urandom_range(1, 4));
            start = 1'b0;
            for (int k = 0; k < int'($urandom_range(0, N + 4)); k++) begin
                if ($urandom_range(0, 3) == 0) start = ~start;
                if ($urandom_range(0, 3) == 0) A = N'($urandom);
                if ($urandom_range(0, 3) == 0) B = N'($urandom);
                cycles(1);
            end
            start = 1'b0;
            cycles(1);
        end

        begin
            int budget;
            budget = 0;
            while (sb.size() > 0 && budget < 200) begin
                cycles(1);
                budget++;
            end
            check("drain", 64'(sb.size()), 64'(0));
        end
        cycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
Sequencing controller and shift-add datapath for the unsigned sequential multiplier. It sits downstream of the operand-capture/debounce subsystem, taking A, B and its level `start`. On each new start request it runs an N-iteration shift-add multiply, then presents a registered 2N-bit product with a one-cycle valid pulse. It also exposes busy and state outputs for LEDs and display sequencing.

Parameters:
N, 8, operand width in bits (N >= 2); product width is 2N.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  level request from capture subsystem; may stay high for many cycles
A  input  N  multiplicand, sampled only at job launch
B  input  N  multiplier, sampled only at job launch
Y  output  2N  product, registered, holds last result
valid  output  1  one-cycle pulse when Y is updated
busy  output  1  high while a job is in progress
state  output  2  current FSM state code (IDLE=0, CALC=1, DONE=2)

Behaviour:
- Reset: asynchronous, active-low; clock clk. Reset value of every output:
  - Y=0, valid=0, busy=0, state=IDLE.
  - Internal M=0, P=0, Q=0, cnt=0, zero_flag=0.
  - start_q=1. Because start_q resets high, a start held high through reset does not launch a job; start must go low, then high.
- Edge detection:
  - start_q <= start every cycle, in every state.
  - launch = start & ~start_q & (state==IDLE).
- Registers:
  - M (N bits): multiplicand.
  - Q (N bits): multiplier, which becomes the product low half.
  - P (N+1 bits): accumulator with carry bit.
  - cnt: $clog2(N+1) bits.
- IDLE:
  - valid=0, busy=0.
  - On launch: M<=A, Q<=B, P<=0, cnt<=0, busy<=1.
  - If A==0 or B==0: zero_flag<=1 and go to DONE. Otherwise go to CALC.
- CALC (one iteration per cycle):
  - sum = P + (Q[0] ? {1'b0,M} : 0), computed in N+1 bits.
  - {P,Q} <= {1'b0, sum, Q} >> 1, i.e. P <= sum>>1 and Q <= {sum[0], Q[N-1:1]}.
  - cnt <= cnt+1.
  - When cnt==N-1, the N-th iteration completes and the FSM goes to DONE.
- DONE (exactly one cycle):
  - Y <= zero_flag ? 0 : {P[N-1:0], Q}.
  - valid<=1, busy<=0, zero_flag<=0, go to IDLE.
- Valid pulse: valid is cleared on the next edge, so it is high for exactly one cycle.
- Latency, with launch sampled at edge E0:
  - Normal case: CALC covers E1..EN; Y and valid are registered at E(N+1); valid is high in the cycle after E(N+1).
  - Zero-operand case: Y=0 and valid=1 registered at E1.
- busy is high from after E0 through the cycle containing the DONE state.
- Boundary conditions:
  - Start rising edge while busy: ignored, not queued. start_q still tracks start, so a level held across DONE does not relaunch.
  - Operand changes during CALC: no effect; operands are sampled only at launch.
  - Reset mid-CALC or in DONE: job is aborted, Y returns to 0, no valid pulse is emitted.
  - Maximum operands: no overflow. (2^N-1)^2 fits in 2N bits, and the P carry bit captures the intermediate carry.
  - Y is stable between valid pulses.

Test Plan:
- N=8: reset released with start=0; A=13, B=11; start 0->1 and held high 20 cycles -> busy high after E0, valid pulse one cycle after E9 (N+1), Y=143 (0x008F); exactly one valid pulse, no relaunch while start stays high.
- A=255, B=255, start rising edge -> Y=65025 (0xFE01) after the same latency; confirms the P carry bit.
- A=0, B=200, start rising edge -> state goes IDLE->DONE->IDLE; valid one cycle after E1; Y=0; busy high for exactly one cycle.
- Job A=7, B=9 launched; at E3 A/B change to 3/3 and start toggles 0->1 -> result Y=63; only one valid pulse; no second job follows.
- Reset asserted low at E4 of a CALC for 6*5 -> Y=0, state=IDLE, busy=0 immediately (asynchronous); no valid pulse afterwards until a new start edge.
- start held high through reset deassertion -> no launch; start 1->0->1 -> job launches with correct product.
